// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM/writeback stage sequencer.
// Contents: FSM state encoding, access size codes, alignment check and
// byte-enable helpers used by mem_stage_ctrl and load_filter.
package mem_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // True when the low address bits are a legal offset for the access size.
  // The illegal size code is never aligned, so it folds into the same error.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~lo[0];
      SZ_WORD: ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian lane enables for a store.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << lo;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_filter.sv
// Combinational load data filter: picks the addressed byte/half lane out of a
// little-endian memory word and sign- or zero-extends it to NBITS.
// Ports:
//   rdata_i      memory read word
//   addr_lo_i    byte offset within the word
//   size_i       access size code (byte/half/word)
//   unsigned_i   zero-extend instead of sign-extend
//   value_o      extended load value
module load_filter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic [NBITS-1:0] rdata_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  output logic [NBITS-1:0] value_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sign_b;
  logic        sign_h;

  always_comb begin
    unique case (addr_lo_i)
      2'd0: lane_b = rdata_i[7:0];
      2'd1: lane_b = rdata_i[15:8];
      2'd2: lane_b = rdata_i[23:16];
      2'd3: lane_b = rdata_i[31:24];
    endcase
    lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sign_b = ~unsigned_i & lane_b[7];
    sign_h = ~unsigned_i & lane_h[15];

    case (size_i)
      SZ_BYTE: value_o = {{(NBITS-8){sign_b}}, lane_b};
      SZ_HALF: value_o = {{(NBITS-16){sign_h}}, lane_h};
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM/writeback stage sequencer. Accepts one load, store or non-memory op per
// cycle, runs a req/ack transaction to data memory with variable latency while
// stalling upstream, filters load data and registers the writeback value
// (LUI immediate / load data / ALU result).
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
// cycles without ack (o_err pulse, no writeback).
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_valid .. i_extend       MEM-stage op and operands
//   o_dm_req/we/addr/wdata/be data memory request (held until ack)
//   i_dm_ack, i_dm_rdata      memory completion pulse and read data
//   o_stall                   freeze upstream stages
//   o_wb_valid, o_wb_data     one-cycle writeback strobe and value
//   o_err                     one-cycle error pulse
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned NBITS   = 32,
  parameter int unsigned ABITS   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic             i_lui,
  input  logic             i_mem_to_reg,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [ABITS-1:0] i_addr,
  input  logic [NBITS-1:0] i_wdata,
  input  logic [NBITS-1:0] i_alu_result,
  input  logic [NBITS-1:0] i_extend,
  output logic             o_dm_req,
  output logic             o_dm_we,
  output logic [ABITS-1:0] o_dm_addr,
  output logic [NBITS-1:0] o_dm_wdata,
  output logic [3:0]       o_dm_be,
  input  logic             i_dm_ack,
  input  logic [NBITS-1:0] i_dm_rdata,
  output logic             o_stall,
  output logic             o_wb_valid,
  output logic [NBITS-1:0] o_wb_data,
  output logic             o_err
);

  state_t state_q, state_d;

  // Request side registers
  logic             req_q, req_d;
  logic             we_q;
  logic [ABITS-1:0] addr_q;
  logic [NBITS-1:0] wdata_q;
  logic [3:0]       be_q;

  // Op context captured at accept, used when the ack arrives
  logic             lui_q;
  logic             m2r_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [1:0]       lo_q;
  logic [NBITS-1:0] ext_q;
  logic [NBITS-1:0] alu_q;

  // Writeback / error registers
  logic             wb_valid_q, wb_valid_d;
  logic [NBITS-1:0] wb_data_q, wb_data_d;
  logic             err_q, err_d;

  logic             accept;
  logic             stall;
  logic             tmo_hit;
  logic [NBITS-1:0] wdata_rep;
  logic [NBITS-1:0] filt_data;

  // Decode of the op currently presented
  logic mem_op;
  logic acc_err;
  logic acc_mem;
  logic acc_alu;

  always_comb begin
    mem_op  = i_mem_read | i_mem_write;
    acc_err = i_valid & mem_op &
              ((i_mem_read & i_mem_write) | ~is_aligned(i_size, i_addr[1:0]));
    acc_mem = i_valid & mem_op & ~acc_err;
    acc_alu = i_valid & ~mem_op;
  end

  always_comb begin
    case (i_size)
      SZ_BYTE: wdata_rep = {(NBITS/8){i_wdata[7:0]}};
      SZ_HALF: wdata_rep = {(NBITS/16){i_wdata[15:0]}};
      default: wdata_rep = i_wdata;
    endcase
  end

  load_filter #(
    .NBITS(NBITS)
  ) u_load_filter (
    .rdata_i   (i_dm_rdata),
    .addr_lo_i (lo_q),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .value_o   (filt_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;

  // Counts WAIT cycles; IDLE always clears it so every WAIT entry starts at 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires in the TIMEOUT-th WAIT cycle; a coincident ack completes normally.
  assign tmo_hit = (state_q == ST_WAIT) && (cnt_q == CntW'(TIMEOUT - 1)) && !i_dm_ack;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (acc_mem) state_d = ST_WAIT;
      ST_WAIT: if (i_dm_ack || tmo_hit) state_d = ST_IDLE;
    endcase
  end

  // Output / next-value logic
  always_comb begin
    stall      = 1'b0;
    accept     = 1'b0;
    req_d      = req_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall = acc_mem;
        if (acc_mem) begin
          accept = 1'b1;
          req_d  = 1'b1;
        end
        if (acc_alu) begin
          wb_valid_d = 1'b1;
          wb_data_d  = i_lui ? i_extend : i_alu_result;
        end
        if (acc_err) err_d = 1'b1;
      end
      ST_WAIT: begin
        stall = ~i_dm_ack & ~tmo_hit;
        if (i_dm_ack) begin
          req_d = 1'b0;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = lui_q ? ext_q : (m2r_q ? filt_data : alu_q);
          end
        end else if (tmo_hit) begin
          req_d = 1'b0;
          err_d = 1'b1;
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lui_q      <= 1'b0;
      m2r_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      lo_q       <= '0;
      ext_q      <= '0;
      alu_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      req_q      <= req_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      if (accept) begin
        we_q    <= i_mem_write;
        addr_q  <= {i_addr[ABITS-1:2], 2'b00};
        wdata_q <= wdata_rep;
        be_q    <= byte_en(i_size, i_addr[1:0]);
        lui_q   <= i_lui;
        m2r_q   <= i_mem_to_reg;
        size_q  <= i_size;
        uns_q   <= i_unsigned;
        lo_q    <= i_addr[1:0];
        ext_q   <= i_extend;
        alu_q   <= i_alu_result;
      end
    end
  end

  assign o_dm_req   = req_q;
  assign o_dm_we    = we_q;
  assign o_dm_addr  = addr_q;
  assign o_dm_wdata = wdata_q;
  assign o_dm_be    = be_q;
  assign o_stall    = stall;
  assign o_wb_valid = wb_valid_q;
  assign o_wb_data  = wb_data_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases followed by random
// ops, each checked against an arithmetic model of the stage's rules.
module tb_mem_stage_ctrl;

  localparam int unsigned TIMEOUT = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_mem_read, i_mem_write, i_lui, i_mem_to_reg, i_unsigned;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata, i_alu_result, i_extend;
  logic        o_dm_req, o_dm_we;
  logic [31:0] o_dm_addr, o_dm_wdata;
  logic [3:0]  o_dm_be;
  logic        i_dm_ack;
  logic [31:0] i_dm_rdata;
  logic        o_stall, o_wb_valid, o_err;
  logic [31:0] o_wb_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  mem_stage_ctrl #(
    .NBITS  (32),
    .ABITS  (32),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_lui       (i_lui),
    .i_mem_to_reg(i_mem_to_reg),
    .i_size      (i_size),
    .i_unsigned  (i_unsigned),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_alu_result(i_alu_result),
    .i_extend    (i_extend),
    .o_dm_req    (o_dm_req),
    .o_dm_we     (o_dm_we),
    .o_dm_addr   (o_dm_addr),
    .o_dm_wdata  (o_dm_wdata),
    .o_dm_be     (o_dm_be),
    .i_dm_ack    (i_dm_ack),
    .i_dm_rdata  (i_dm_rdata),
    .o_stall     (o_stall),
    .o_wb_valid  (o_wb_valid),
    .o_wb_data   (o_wb_data),
    .o_err       (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input logic ack);
    i_valid    = 1'b0;
    i_dm_ack   = ack;
    i_dm_rdata = $urandom;
    #1;
    chk("idle_stall", o_stall, 0);
    @(posedge i_clk);
    #1;
    i_dm_ack = 1'b0;
    chk("idle_wbv", o_wb_valid, 0);
    chk("idle_err", o_err, 0);
    chk("idle_req", o_dm_req, 0);
  endtask

  // Entered and left at posedge+1 of a cycle where the stage is IDLE.
  // lat = WAIT cycles without ack before the ack cycle.
  task automatic do_op(input logic rd, input logic wr, input logic lui, input logic m2r,
                       input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] alu,
                       input logic [31:0] ext, input logic [31:0] rdata, input int lat);
    logic        mem, err;
    int          nbytes, be_i;
    logic [3:0]  be;
    logic [31:0] wrep, lval, mask, wb;
    logic [63:0] m64;

    mem    = rd | wr;
    nbytes = 1 << sz;
    err    = mem && ((rd && wr) || sz == 2'd3 || (addr % nbytes) != 0);
    be_i   = ((1 << nbytes) - 1) << addr[1:0];
    be     = be_i[3:0];
    wrep   = '0;
    lval   = '0;
    mask   = '0;
    if (nbytes <= 4) begin
      for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
      m64  = (64'd1 << (8 * nbytes)) - 64'd1;
      mask = m64[31:0];
      lval = (rdata >> (8 * addr[1:0])) & mask;
      if (!uns && lval[8*nbytes-1]) lval = lval | ~mask;
    end
    if (lui) wb = ext;
    else if (rd && m2r) wb = lval;
    else wb = alu;

    i_valid      = 1'b1;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_lui        = lui;
    i_mem_to_reg = m2r;
    i_size       = sz;
    i_unsigned   = uns;
    i_addr       = addr;
    i_wdata      = wdata;
    i_alu_result = alu;
    i_extend     = ext;
    i_dm_ack     = 1'b0;
    #1;
    chk("accept_stall", o_stall, mem && !err);

    if (!mem || err) begin
      @(posedge i_clk);
      #1;
      chk("nm_wbv", o_wb_valid, !mem);
      if (!mem) chk("nm_wbdata", o_wb_data, wb);
      chk("nm_err", o_err, err);
      chk("nm_req", o_dm_req, 0);
      return;
    end

    @(posedge i_clk);
    #1;
    chk("req_set", o_dm_req, 1);
    chk("req_we", o_dm_we, wr);
    chk("req_addr", o_dm_addr, {addr[31:2], 2'b00});
    chk("req_be", o_dm_be, be);
    if (wr) chk("req_wdata", o_dm_wdata, wrep);
    for (int k = 0; k < lat; k++) begin
      chk("wait_stall", o_stall, 1);
      chk("wait_wbv", o_wb_valid, 0);
      @(posedge i_clk);
      #1;
      chk("wait_req", o_dm_req, 1);
    end
    i_dm_ack   = 1'b1;
    i_dm_rdata = rdata;
    #1;
    chk("ack_stall", o_stall, 0);
    @(posedge i_clk);
    #1;
    i_dm_ack   = 1'b0;
    i_dm_rdata = $urandom;
    chk("done_req", o_dm_req, 0);
    chk("done_wbv", o_wb_valid, rd);
    if (rd) chk("done_wbdata", o_wb_data, wb);
    chk("done_err", o_err, 0);
  endtask

  initial begin
    logic        rd, wr, lui, m2r, uns;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          kind;

    i_rst_n      = 1'b0;
    i_valid      = 1'b0;
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b0;
    i_lui        = 1'b0;
    i_mem_to_reg = 1'b0;
    i_size       = 2'b00;
    i_unsigned   = 1'b0;
    i_addr       = '0;
    i_wdata      = '0;
    i_alu_result = '0;
    i_extend     = '0;
    i_dm_ack     = 1'b0;
    i_dm_rdata   = '0;
    #7;
    chk("rst_req", o_dm_req, 0);
    chk("rst_we", o_dm_we, 0);
    chk("rst_addr", o_dm_addr, 0);
    chk("rst_wdata", o_dm_wdata, 0);
    chk("rst_be", o_dm_be, 0);
    chk("rst_wbv", o_wb_valid, 0);
    chk("rst_wbdata", o_wb_data, 0);
    chk("rst_err", o_err, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // LB / LBU at 0x103, ack three cycles after req
    do_op(1, 0, 0, 1, 2'b00, 0, 32'h103, 0, 32'h77, 0, 32'h80FF_1234, 3);
    chk("lb_value", o_wb_data, 32'hFFFF_FF80);
    idle_cycle(0);
    do_op(1, 0, 0, 1, 2'b00, 1, 32'h103, 0, 32'h77, 0, 32'h80FF_1234, 3);
    chk("lbu_value", o_wb_data, 32'h0000_0080);
    // SH at 0x202
    do_op(0, 1, 0, 0, 2'b01, 0, 32'h202, 32'h0000_ABCD, 0, 0, 0, 1);
    chk("sh_wdata", o_dm_wdata, 32'hABCD_ABCD);
    chk("sh_be", o_dm_be, 4'b1100);
    // Misaligned LW then ADD immediately
    do_op(1, 0, 0, 1, 2'b10, 0, 32'h101, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 0, 2'b10, 0, 0, 0, 32'h5, 0, 0, 0);
    chk("add_value", o_wb_data, 32'h5);
    // LW acked with req, LUI with no bubble
    do_op(1, 0, 0, 1, 2'b10, 0, 32'h40, 0, 0, 0, 32'hDEAD_BEEF, 0);
    do_op(0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h9, 32'h1234_0000, 0, 0);
    chk("lui_value", o_wb_data, 32'h1234_0000);
    idle_cycle(1);

    // Reset while WAIT, then a stale ack after release
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_size = 2'b10; i_addr = 32'h80;
    @(posedge i_clk);
    #1;
    chk("rstw_req", o_dm_req, 1);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk("rstw_req0", o_dm_req, 0);
    chk("rstw_stall", o_stall, 0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    idle_cycle(1);
    idle_cycle(0);

`ifdef MEM_TIMEOUT_EN
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_lui = 1'b0;
    i_size = 2'b10; i_addr = 32'h84;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      chk("tmo_stall", o_stall, 1);
      chk("tmo_req", o_dm_req, 1);
      @(posedge i_clk);
      #1;
    end
    chk("tmo_release", o_stall, 0);
    chk("tmo_req_last", o_dm_req, 1);
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    chk("tmo_req_drop", o_dm_req, 0);
    chk("tmo_err", o_err, 1);
    chk("tmo_wbv", o_wb_valid, 0);
    idle_cycle(0);
`endif

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind >= 3 && kind <= 5) || kind == 9;
      wr   = (kind >= 6);
      lui  = ($urandom_range(0, 3) == 0);
      m2r  = ($urandom_range(0, 3) != 0);
      uns  = $urandom_range(0, 1);
      sz   = ($urandom_range(0, 7) != 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      addr = $urandom;
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      do_op(rd, wr, lui, m2r, sz, uns, addr, $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) idle_cycle($urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
